// File: rtl/fft_pkg.sv
// Shared definitions for the FFT controller family: sequencer state encoding
// and the width of the stage counter for a given transform size.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_t;

  // The stage counter must also hold N_LOG2 itself, the value it reaches
  // after the last stage has been issued.
  function automatic int stage_width(input int n_log2);
    return $clog2(n_log2 + 1);
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth shift register that aligns write-back strobes and indices with
// the complex adder output.
module fft_wb_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // NOTE: every stage is reset, not just the head, because the strobe bit
  // riding in each slot must never emit a stale write after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT address/control sequencer: walks every butterfly of every stage,
// drains the adder between stages and delays issue info to form write-back.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2  = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic                             i_stall,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_issue,
  output logic [N_LOG2-1:0]                o_addr_a,
  output logic [N_LOG2-1:0]                o_addr_b,
  output logic [N_LOG2-2:0]                o_tw_idx,
  output logic [stage_width(N_LOG2)-1:0]   o_stage,
  output logic                             o_wr_en,
  output logic [N_LOG2-1:0]                o_wr_addr_a,
  output logic [N_LOG2-1:0]                o_wr_addr_b
);

  localparam int STAGE_W = stage_width(N_LOG2);
  localparam int K_W     = N_LOG2 - 1;
  localparam int DRAIN_W = $clog2(ADD_LAT + 1);
  localparam int WB_W    = 1 + 2 * N_LOG2;

  fft_state_t         state, state_d;
  logic [K_W-1:0]     k;
  logic [STAGE_W-1:0] s;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               issue;
  logic               last_bfly;

  assign last_bfly = &k;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state;
    issue   = 1'b0;
    case (state)
      ST_IDLE: if (i_start) state_d = ST_RUN;
      ST_RUN: begin
        issue = ~i_stall;
        if (issue && last_bfly) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_W'(ADD_LAT - 1))
          state_d = (s == STAGE_W'(N_LOG2)) ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      s         <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_d;
      if (issue) k <= last_bfly ? '0 : k + 1'b1;
      if (issue && last_bfly) s <= s + 1'b1;
      else if (state == ST_DONE) s <= '0;
      drain_cnt <= (state == ST_DRAIN && state_d == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  // Butterfly index decode; only meaningful while s < N_LOG2, i.e. in RUN.
  logic [K_W-1:0]     pos, grp, mask, tw_raw;
  logic [N_LOG2-1:0]  a_raw, b_raw;
  logic [STAGE_W-1:0] tw_sh;

  always_comb begin
    mask   = ~({K_W{1'b1}} << s);
    pos    = k & mask;
    grp    = k >> s;
    a_raw  = ({grp, 1'b0} << s) | {1'b0, pos};
    b_raw  = a_raw | (N_LOG2'(1) << s);
    tw_sh  = STAGE_W'(N_LOG2 - 1) - s;
    tw_raw = pos << tw_sh;
  end

  logic in_run;
  assign in_run   = (state == ST_RUN);
  assign o_busy   = (state != ST_IDLE);
  assign o_done   = (state == ST_DONE);
  assign o_issue  = issue;
  assign o_stage  = s;
  assign o_addr_a = in_run ? a_raw  : '0;
  assign o_addr_b = in_run ? b_raw  : '0;
  assign o_tw_idx = in_run ? tw_raw : '0;

  logic [WB_W-1:0] wb_in, wb_out;
  assign wb_in = {o_issue, o_addr_a, o_addr_b};

  fft_wb_delay #(
    .WIDTH (WB_W),
    .DEPTH (ADD_LAT)
  ) u_wb_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (wb_in),
    .dout  (wb_out)
  );

  assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = wb_out;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: N=8 with adder latency 1 and 3,
// stall, ignored restarts and mid-transform reset, against hand timelines.
module tb_fft_stage_sequencer;

  localparam int NCYC = 26;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0, i_stall = 1'b0;
  logic       start3 = 1'b0, stall3 = 1'b0;

  logic       busy, done, issue, wr_en;
  logic [2:0] addr_a, addr_b, wr_a, wr_b;
  logic [1:0] tw, stage;
  logic       busy3, done3, issue3, wr_en3;
  logic [2:0] addr_a3, addr_b3, wr_a3, wr_b3;
  logic [1:0] tw3, stage3;

  fft_stage_sequencer #(.N_LOG2(3), .ADD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stall(i_stall),
    .o_busy(busy), .o_done(done), .o_issue(issue),
    .o_addr_a(addr_a), .o_addr_b(addr_b), .o_tw_idx(tw), .o_stage(stage),
    .o_wr_en(wr_en), .o_wr_addr_a(wr_a), .o_wr_addr_b(wr_b)
  );

  fft_stage_sequencer #(.N_LOG2(3), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start3), .i_stall(stall3),
    .o_busy(busy3), .o_done(done3), .o_issue(issue3),
    .o_addr_a(addr_a3), .o_addr_b(addr_b3), .o_tw_idx(tw3), .o_stage(stage3),
    .o_wr_en(wr_en3), .o_wr_addr_a(wr_a3), .o_wr_addr_b(wr_b3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-cycle traces; bit/index c holds the value seen in cycle c.
  logic [31:0] iss_v, done_v, busy_v, wr_v, iss3_v, wr3_v, done3_v, busy3_v;
  logic [2:0]  a_l [32];
  logic [2:0]  b_l [32];
  logic [1:0]  tw_l [32];
  logic [1:0]  st_l [32];
  logic [2:0]  wa_l [32];
  logic [2:0]  wb_l [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    for (int c = 1; c <= NCYC; c++)
      check($sformatf("%s@%0d", name, c), 32'(got_v[c]), 32'(exp_v[c]));
  endtask

  // Start is sampled at edge 0; cycle c is the interval after edge c-1.
  task automatic run_txn(input int st_lo, input int st_hi, input int r1, input int r2,
                         input logic with3);
    iss_v = '0; done_v = '0; busy_v = '0; wr_v = '0;
    iss3_v = '0; wr3_v = '0; done3_v = '0; busy3_v = '0;
    @(posedge clk); #1;
    i_start = 1'b1; start3 = with3; i_stall = 1'b0;
    for (int c = 1; c <= NCYC; c++) begin
      @(posedge clk); #1;
      i_start = (c == r1) || (c == r2);
      start3  = 1'b0;
      i_stall = (c >= st_lo) && (c <= st_hi);
      @(negedge clk);
      iss_v[c] = issue; done_v[c] = done; busy_v[c] = busy; wr_v[c] = wr_en;
      iss3_v[c] = issue3; wr3_v[c] = wr_en3; done3_v[c] = done3; busy3_v[c] = busy3;
      a_l[c] = addr_a; b_l[c] = addr_b; tw_l[c] = tw; st_l[c] = stage;
      wa_l[c] = wr_a; wb_l[c] = wr_b;
    end
    i_stall = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs",  32'({busy, done, issue, wr_en, addr_a, addr_b, tw, stage, wr_a, wr_b}), 32'd0);
    check("rst_outs3", 32'({busy3, done3, issue3, wr_en3, addr_a3, addr_b3, tw3, stage3, wr_a3, wr_b3}), 32'd0);
    rst_n = 1'b1;

    // Plain transform on both latencies.
    run_txn(100, 0, -1, -1, 1'b1);
    check_seq("issue",  iss_v,  32'h0000_7BDE);
    check_seq("done",   done_v, 32'h0001_0000);
    check_seq("busy",   busy_v, 32'h0001_FFFE);
    check_seq("wr_en",  wr_v,   32'h0000_F7BC);
    check("s0k0_a", 32'(a_l[1]), 0);   check("s0k0_b", 32'(b_l[1]), 1);
    check("s0k0_tw", 32'(tw_l[1]), 0); check("s0k3_a", 32'(a_l[4]), 6);
    check("s0k3_b", 32'(b_l[4]), 7);
    check("s1k1_a", 32'(a_l[7]), 1);   check("s1k1_b", 32'(b_l[7]), 3);
    check("s1k1_tw", 32'(tw_l[7]), 2); check("s1k1_st", 32'(st_l[7]), 1);
    check("s1k2_a", 32'(a_l[8]), 4);   check("s1k2_b", 32'(b_l[8]), 6);
    check("s1k1_wa", 32'(wa_l[8]), 1); check("s1k1_wb", 32'(wb_l[8]), 3);
    check("s2k3_a", 32'(a_l[14]), 3);  check("s2k3_b", 32'(b_l[14]), 7);
    check("s2k3_tw", 32'(tw_l[14]), 3); check("s2k3_st", 32'(st_l[14]), 2);
    check_seq("lat3_issue", iss3_v,  32'h0007_8F1E);
    check_seq("lat3_wr_en", wr3_v,   32'h003C_78F0);
    check_seq("lat3_done",  done3_v, 32'h0040_0000);
    check_seq("lat3_busy",  busy3_v, 32'h007F_FFFE);

    // Three stall cycles in stage 1 push everything out by three.
    run_txn(7, 9, -1, -1, 1'b0);
    check_seq("stl_issue", iss_v,  32'h0003_DC5E);
    check_seq("stl_done",  done_v, 32'h0008_0000);
    check_seq("stl_busy",  busy_v, 32'h000F_FFFE);
    check_seq("stl_wr_en", wr_v,   32'h0007_B8BC);
    for (int c = 7; c <= 10; c++) begin
      check($sformatf("stl_a@%0d", c), 32'(a_l[c]), 1);
      check($sformatf("stl_b@%0d", c), 32'(b_l[c]), 3);
    end

    // Restart requests in RUN and in DONE are ignored.
    run_txn(100, 0, 3, 16, 1'b0);
    check_seq("rs_issue", iss_v,  32'h0000_7BDE);
    check_seq("rs_done",  done_v, 32'h0001_0000);
    check_seq("rs_busy",  busy_v, 32'h0001_FFFE);

    // Reset asserted during stage 1, then a fresh transform.
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_stage", 32'(stage), 1);
    check("pre_rst_busy",  32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({busy, done, issue, wr_en, addr_a, addr_b, tw, stage, wr_a, wr_b}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    @(negedge clk);
    check("post_rst_issue", 32'(issue), 1);
    check("post_rst_a",     32'(addr_a), 0);
    check("post_rst_b",     32'(addr_b), 1);
    check("post_rst_stage", 32'(stage), 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
